// File: rtl/cnn_seq_ctrl_pkg.sv
// Shared sizing defaults and the sequencer state type for the CNN frame controller.
// Edge lengths are in elements; DATA_WIDTH is the width of one pixel, weight or result.
package cnn_seq_ctrl_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int IFMAP_SIZE      = 4;
    localparam int KERNEL_SIZE     = 2;
    localparam int POOL_OFMAP_SIZE = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DRAIN   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/seq_out_streamer.sv
// Result buffer that streams N_OUT words in index order while active; one word per out handshake.
// Data is registered, so out_data holds steady while out_ready is low.
module seq_out_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int N_OUT      = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load_i,
    input  logic [N_OUT*DATA_WIDTH-1:0] load_dat_i,
    input  logic                        active_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [DATA_WIDTH-1:0]       out_data_o,
    output logic                        out_last_o,
    output logic                        done_o
);

    localparam int IW = $clog2(N_OUT + 1);
    localparam int IS = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_OUT - 1);

    logic [N_OUT-1:0][DATA_WIDTH-1:0] buf_q, buf_d;
    logic [IW-1:0]                    idx_q, idx_d;
    logic                             fire;
    logic                             last;

    always_comb begin
        buf_d       = buf_q;
        idx_d       = idx_q;
        last        = active_i && (idx_q == LAST_IDX);
        fire        = active_i && out_ready_i;
        out_valid_o = active_i;
        out_last_o  = last;
        done_o      = fire && last;
        out_data_o  = '0;
        if (active_i) begin
            out_data_o = buf_q[idx_q[IS-1:0]];
        end
        if (load_i) begin
            buf_d = load_dat_i;
        end
        if (fire) begin
            idx_d = last ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q <= '0;
            idx_q <= '0;
        end else begin
            buf_q <= buf_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/cnn_seq_ctrl.sv
// Frame sequencer: buffers an ifmap and kernel, runs the accelerator, then streams the pooled result.
// RUN starts the cycle after both buffers fill; inputs stall outside IDLE/LOAD, results wait on out_ready.
module cnn_seq_ctrl #(
    parameter int DATA_WIDTH      = cnn_seq_ctrl_pkg::DATA_WIDTH,
    parameter int IFMAP_SIZE      = cnn_seq_ctrl_pkg::IFMAP_SIZE,
    parameter int KERNEL_SIZE     = cnn_seq_ctrl_pkg::KERNEL_SIZE,
    parameter int POOL_OFMAP_SIZE = cnn_seq_ctrl_pkg::POOL_OFMAP_SIZE,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               px_valid,
    output logic                                               px_ready,
    input  logic [DATA_WIDTH-1:0]                              px_data,
    input  logic                                               w_valid,
    output logic                                               w_ready,
    input  logic [DATA_WIDTH-1:0]                              w_data,
    output logic                                               acc_en,
    output logic [DATA_WIDTH*IFMAP_SIZE*IFMAP_SIZE-1:0]        acc_ifmap,
    output logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0]      acc_weights,
    input  logic [DATA_WIDTH*POOL_OFMAP_SIZE*POOL_OFMAP_SIZE-1:0] acc_ofmap,
    input  logic                                               acc_done,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic [DATA_WIDTH-1:0]                              out_data,
    output logic                                               out_last,
    output logic                                               busy,
    output logic                                               err_timeout
);

    import cnn_seq_ctrl_pkg::*;

    localparam int NPX  = IFMAP_SIZE * IFMAP_SIZE;
    localparam int NW   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int NOUT = POOL_OFMAP_SIZE * POOL_OFMAP_SIZE;
    localparam int PXW  = $clog2(NPX + 1);
    localparam int WW   = $clog2(NW + 1);
    localparam int RW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PXS  = (NPX > 1) ? $clog2(NPX) : 1;
    localparam int WS   = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [PXW-1:0] NPX_C    = PXW'(NPX);
    localparam logic [WW-1:0]  NW_C     = WW'(NW);
    localparam logic [RW-1:0]  RUN_LAST = RW'(TIMEOUT_CYCLES - 1);

    seq_state_e                       state_q, state_d;
    logic [PXW-1:0]                   px_cnt_q, px_cnt_d;
    logic [WW-1:0]                    w_cnt_q, w_cnt_d;
    logic [RW-1:0]                    run_cnt_q, run_cnt_d;
    logic                             err_q, err_d;
    logic [NPX-1:0][DATA_WIDTH-1:0]   ifmap_q;
    logic [NW-1:0][DATA_WIDTH-1:0]    wgt_q;

    logic load_phase;
    logic px_fire;
    logic w_fire;
    logic capture;
    logic clear_buf;
    logic drain_act;
    logic drain_done;

    always_comb begin
        state_d    = state_q;
        px_cnt_d   = px_cnt_q;
        w_cnt_d    = w_cnt_q;
        run_cnt_d  = run_cnt_q;
        err_d      = err_q;
        capture    = 1'b0;
        clear_buf  = 1'b0;
        load_phase = (state_q == ST_IDLE) || (state_q == ST_LOAD);
        px_ready   = load_phase && (px_cnt_q < NPX_C);
        w_ready    = load_phase && (w_cnt_q < NW_C);
        px_fire    = px_valid && px_ready;
        w_fire     = w_valid && w_ready;
        acc_en     = (state_q == ST_RUN);
        busy       = (state_q != ST_IDLE);
        drain_act  = (state_q == ST_DRAIN);

        if (px_fire) begin
            px_cnt_d = px_cnt_q + PXW'(1);
        end
        if (w_fire) begin
            w_cnt_d = w_cnt_q + WW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (px_fire || w_fire) begin
                    err_d   = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
            end
            ST_RUN: begin
                if (acc_done) begin
                    capture = 1'b1;
                    state_d = ST_CAPTURE;
                end else if (run_cnt_q == RUN_LAST) begin
                    // Abort: drop the frame so the next one starts from empty buffers.
                    state_d   = ST_IDLE;
                    err_d     = 1'b1;
                    clear_buf = 1'b1;
                    px_cnt_d  = '0;
                    w_cnt_d   = '0;
                    run_cnt_d = '0;
                end else begin
                    run_cnt_d = run_cnt_q + RW'(1);
                end
            end
            ST_CAPTURE: begin
                state_d   = ST_DRAIN;
                run_cnt_d = '0;
                px_cnt_d  = '0;
                w_cnt_d   = '0;
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A final pixel and final weight landing together still count as one fill event.
        if (load_phase && (px_cnt_d == NPX_C) && (w_cnt_d == NW_C)) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            px_cnt_q  <= '0;
            w_cnt_q   <= '0;
            run_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            px_cnt_q  <= px_cnt_d;
            w_cnt_q   <= w_cnt_d;
            run_cnt_q <= run_cnt_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifmap_q <= '0;
            wgt_q   <= '0;
        end else if (clear_buf) begin
            ifmap_q <= '0;
            wgt_q   <= '0;
        end else begin
            if (px_fire) begin
                ifmap_q[px_cnt_q[PXS-1:0]] <= px_data;
            end
            if (w_fire) begin
                wgt_q[w_cnt_q[WS-1:0]] <= w_data;
            end
        end
    end

    assign acc_ifmap   = ifmap_q;
    assign acc_weights = wgt_q;
    assign err_timeout = err_q;

    seq_out_streamer #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_OUT      (NOUT)
    ) u_streamer (
        .clk         (clk),
        .reset       (reset),
        .load_i      (capture),
        .load_dat_i  (acc_ofmap),
        .active_i    (drain_act),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .done_o      (drain_done)
    );

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// Bench for cnn_seq_ctrl: random frames against a frame-level reference model, plus a short-timeout instance.
module tb_cnn_seq_ctrl;

    localparam int TO_MAIN = 1024;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         px_valid, px_ready, w_valid, w_ready;
    logic [7:0]   px_data, w_data;
    logic         acc_en, acc_done, out_valid, out_ready, out_last, busy, err_timeout;
    logic [127:0] acc_ifmap;
    logic [31:0]  acc_weights, acc_ofmap;
    logic [7:0]   out_data;

    logic         t_px_valid, t_px_ready, t_w_valid, t_w_ready;
    logic [7:0]   t_px_data, t_w_data;
    logic         t_acc_en, t_acc_done, t_out_valid, t_out_ready, t_out_last, t_busy, t_err;
    logic [127:0] t_acc_ifmap;
    logic [31:0]  t_acc_weights, t_acc_ofmap;
    logic [7:0]   t_out_data;

    cnn_seq_ctrl u_dut (
        .clk(clk), .reset(reset),
        .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .acc_en(acc_en), .acc_ifmap(acc_ifmap), .acc_weights(acc_weights),
        .acc_ofmap(acc_ofmap), .acc_done(acc_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err_timeout(err_timeout)
    );

    cnn_seq_ctrl #(.TIMEOUT_CYCLES(8)) u_dut_to (
        .clk(clk), .reset(reset),
        .px_valid(t_px_valid), .px_ready(t_px_ready), .px_data(t_px_data),
        .w_valid(t_w_valid), .w_ready(t_w_ready), .w_data(t_w_data),
        .acc_en(t_acc_en), .acc_ifmap(t_acc_ifmap), .acc_weights(t_acc_weights),
        .acc_ofmap(t_acc_ofmap), .acc_done(t_acc_done),
        .out_valid(t_out_valid), .out_ready(t_out_ready), .out_data(t_out_data), .out_last(t_out_last),
        .busy(t_busy), .err_timeout(t_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_note(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
    endtask

    // Reference accelerator: 3x3 valid convolution, then 2x2 stride-1 max pool, low byte kept.
    function automatic logic [31:0] accel(input logic [7:0] p [16], input logic [7:0] w [4]);
        int conv [3][3];
        int s, m;
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int a = 0; a < 2; a++)
                    for (int b = 0; b < 2; b++)
                        s += int'(p[(i + a) * 4 + j + b]) * int'($signed(w[a * 2 + b]));
                conv[i][j] = s;
            end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                m = conv[i][j];
                for (int a = 0; a < 2; a++)
                    for (int b = 0; b < 2; b++)
                        if (conv[i + a][j + b] > m) m = conv[i + a][j + b];
                r[(i * 2 + j) * 8 +: 8] = m[7:0];
            end
        return r;
    endfunction

    logic [7:0] cur_pix [16];
    logic [7:0] cur_wgt [4];
    int         done_delay = 20;
    int         rdy_mode   = 0;

    // Accelerator stand-in: done after done_delay RUN cycles, random done/ofmap noise elsewhere.
    initial begin
        int rcnt;
        rcnt = 0;
        acc_done = 1'b0;
        acc_ofmap = '0;
        forever begin
            @(posedge clk); #1;
            if (acc_en) begin
                rcnt++;
                acc_done  = (rcnt == done_delay);
                acc_ofmap = acc_done ? accel(cur_pix, cur_wgt) : $urandom;
            end else begin
                rcnt = 0;
                acc_done  = ($urandom % 6 == 0);
                acc_ofmap = $urandom;
            end
        end
    end

    initial begin
        int k;
        logic [3:0] pat;
        pat = 4'b1001;
        k = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: out_ready = 1'($urandom % 2);
                1: begin
                    if (out_valid) begin
                        out_ready = pat[k % 4];
                        k++;
                    end else begin
                        out_ready = 1'b0;
                        k = 0;
                    end
                end
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Frame-level reference: phase 0 idle, 1 loading, 2 running, 3 capture, 4 draining.
    int         m_ph, m_np, m_nw, m_rc;
    bit         m_err;
    logic [7:0] m_pix [16];
    logic [7:0] m_wgt [4];
    logic [7:0] m_q [$];
    logic [7:0] act_out [$];

    always @(negedge clk) begin
        logic epr, ewr;
        logic [7:0]   eod;
        logic [127:0] ei;
        logic [31:0]  ew;
        if (reset) begin
            m_ph = 0; m_np = 0; m_nw = 0; m_rc = 0; m_err = 0;
            m_q.delete();
        end
        epr = (m_ph <= 1) && (m_np < 16);
        ewr = (m_ph <= 1) && (m_nw < 4);
        eod = 8'h00;
        if (m_ph == 4) eod = m_q[0];
        chk("px_ready", px_ready, epr);
        chk("w_ready", w_ready, ewr);
        chk("busy", busy, m_ph != 0);
        chk("acc_en", acc_en, m_ph == 2);
        chk("out_valid", out_valid, m_ph == 4);
        chk("out_data", out_data, eod);
        chk("out_last", out_last, (m_ph == 4) && (m_q.size() == 1));
        chk("err_timeout", err_timeout, m_err);
        if (m_ph == 2) begin
            ei = '0;
            ew = '0;
            for (int i = 0; i < 16; i++) ei[i * 8 +: 8] = m_pix[i];
            for (int i = 0; i < 4; i++) ew[i * 8 +: 8] = m_wgt[i];
            chk("acc_ifmap", acc_ifmap, ei);
            chk("acc_weights", acc_weights, ew);
        end
        if (!reset) begin
            case (m_ph)
                0, 1: begin
                    if (px_valid && epr) begin m_pix[m_np] = px_data; m_np++; end
                    if (w_valid && ewr) begin m_wgt[m_nw] = w_data; m_nw++; end
                    if (m_ph == 0 && ((px_valid && epr) || (w_valid && ewr))) begin
                        m_err = 0;
                        m_ph = 1;
                    end
                    if (m_np == 16 && m_nw == 4) begin m_ph = 2; m_rc = 0; end
                end
                2: begin
                    if (acc_done) begin
                        for (int i = 0; i < 4; i++) m_q.push_back(acc_ofmap[i * 8 +: 8]);
                        m_ph = 3;
                    end else begin
                        m_rc++;
                        if (m_rc == TO_MAIN) begin m_ph = 0; m_np = 0; m_nw = 0; m_err = 1; end
                    end
                end
                3: m_ph = 4;
                default: begin
                    if (out_ready) begin
                        act_out.push_back(out_data);
                        void'(m_q.pop_front());
                        if (m_q.size() == 0) begin m_ph = 0; m_np = 0; m_nw = 0; end
                    end
                end
            endcase
        end
    end

    task automatic send_frame(input int mode, input int plim, input int wlim, input bit full);
        int pi, wi, cyc;
        pi = 0; wi = 0; cyc = 0;
        while ((pi < plim || wi < wlim) && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            case (mode)
                0: begin
                    px_valid = (pi < plim) && ($urandom % 4 != 0);
                    w_valid  = (wi < wlim) && ($urandom % 3 != 0);
                end
                1: begin
                    w_valid  = (wi < wlim);
                    px_valid = (wi >= wlim) && (pi < plim);
                end
                default: begin
                    px_valid = (pi < plim);
                    w_valid  = (wi < wlim) && (pi >= plim - wlim);
                end
            endcase
            px_data = px_valid ? cur_pix[pi % 16] : 8'($urandom);
            w_data  = w_valid ? cur_wgt[wi % 4] : 8'($urandom);
            @(negedge clk);
            if (px_valid && px_ready) pi++;
            if (w_valid && w_ready) wi++;
        end
        if (cyc >= 300) fail_note("load_bound");
        @(posedge clk); #1;
        px_valid = 1'b0;
        w_valid  = 1'b0;
        if (full) begin
            @(negedge clk);
            chk("run_entry", acc_en, 1'b1);
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (busy && c < 600);
        if (busy) fail_note("idle_bound");
    endtask

    task automatic lit_data();
        for (int i = 0; i < 16; i++) cur_pix[i] = 8'(i + 1);
        for (int i = 0; i < 4; i++) cur_wgt[i] = 8'd1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < 16; i++) cur_pix[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) cur_wgt[i] = 8'($urandom);
    endtask

    // Pooled result of ifmap 1..16 with an all-ones 2x2 kernel, worked by hand.
    task automatic check_lit_stream(input string tag);
        logic [7:0] exp [4];
        exp[0] = 8'd34; exp[1] = 8'd38; exp[2] = 8'd50; exp[3] = 8'd54;
        chk({tag, "_count"}, act_out.size(), 4);
        while (act_out.size() < 4) act_out.push_back(8'hxx);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_px%0d", tag, i), act_out[i], exp[i]);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_px_ready"}, px_ready, 1'b1);
        chk({tag, "_w_ready"}, w_ready, 1'b1);
        chk({tag, "_acc_en"}, acc_en, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_last"}, out_last, 1'b0);
        chk({tag, "_out_data"}, out_data, 8'h00);
        chk({tag, "_err"}, err_timeout, 1'b0);
        chk({tag, "_ifmap"}, acc_ifmap, 128'h0);
        chk({tag, "_weights"}, acc_weights, 32'h0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #3;
        px_valid = 1'b0;
        w_valid  = 1'b0;
        reset = 1'b1;
        #1;
        reset_checks(tag);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic timeout_test();
        int n, c;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            t_px_valid = 1'b1;
            t_px_data  = 8'(i + 1);
            t_w_valid  = (i < 4);
            t_w_data   = 8'(i + 1);
        end
        @(posedge clk); #1;
        t_px_valid = 1'b0;
        t_w_valid  = 1'b0;
        n = 0; c = 0;
        while (c < 50) begin
            @(negedge clk);
            c++;
            if (t_acc_en) n++;
            else if (n > 0) break;
        end
        if (c >= 50) fail_note("to_bound");
        chk("to_run_cycles", n, 8);
        chk("to_err_set", t_err, 1'b1);
        chk("to_busy", t_busy, 1'b0);
        chk("to_px_ready", t_px_ready, 1'b1);
        chk("to_w_ready", t_w_ready, 1'b1);
        chk("to_ifmap_cleared", t_acc_ifmap, 128'h0);
        chk("to_idle_outs", {t_out_valid, t_out_last, t_out_data, t_acc_weights}, 42'h0);
        repeat (3) @(negedge clk);
        chk("to_err_sticky", t_err, 1'b1);
        @(posedge clk); #1;
        t_px_valid = 1'b1;
        t_px_data  = 8'h5a;
        @(negedge clk);
        chk("to_err_before_accept", t_err, 1'b1);
        @(posedge clk); #1;
        t_px_valid = 1'b0;
        @(negedge clk);
        chk("to_err_cleared", t_err, 1'b0);
        chk("to_load_busy", t_busy, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        px_valid = 1'b0; w_valid = 1'b0; px_data = '0; w_data = '0;
        t_px_valid = 1'b0; t_w_valid = 1'b0; t_px_data = '0; t_w_data = '0;
        t_acc_done = 1'b0; t_acc_ofmap = '0; t_out_ready = 1'b1;
        lit_data();
        #2;
        reset_checks("por");
        chk("por_to_err", t_err, 1'b0);
        chk("por_to_px_ready", t_px_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        timeout_test();

        lit_data(); done_delay = 20; rdy_mode = 0; act_out.delete();
        send_frame(0, 16, 4, 1'b1);
        wait_idle();
        check_lit_stream("frame_ramp");

        rand_data(); done_delay = 5; act_out.delete();
        send_frame(1, 16, 4, 1'b1);
        wait_idle();
        chk("wfirst_count", act_out.size(), 4);

        rand_data(); done_delay = 1; act_out.delete();
        send_frame(2, 16, 4, 1'b1);
        wait_idle();
        chk("simul_count", act_out.size(), 4);

        lit_data(); done_delay = 20; rdy_mode = 1; act_out.delete();
        send_frame(2, 16, 4, 1'b1);
        wait_idle();
        check_lit_stream("stall_1001");

        rdy_mode = 0;
        rand_data();
        send_frame(0, 6, 2, 1'b0);
        do_reset("rst_load");
        lit_data(); act_out.delete();
        send_frame(0, 16, 4, 1'b1);
        wait_idle();
        check_lit_stream("after_rst_load");

        rdy_mode = 2; rand_data(); done_delay = 3;
        send_frame(0, 16, 4, 1'b1);
        begin
            int c;
            c = 0;
            while (!out_valid && c < 100) begin @(negedge clk); c++; end
            if (c >= 100) fail_note("drain_bound");
        end
        repeat (2) @(negedge clk);
        do_reset("rst_drain");
        rdy_mode = 0; lit_data(); done_delay = 20; act_out.delete();
        send_frame(1, 16, 4, 1'b1);
        wait_idle();
        check_lit_stream("after_rst_drain");

        for (int f = 0; f < 4; f++) begin
            rand_data();
            done_delay = $urandom_range(1, 30);
            act_out.delete();
            send_frame($urandom_range(0, 2), 16, 4, 1'b1);
            wait_idle();
            chk($sformatf("rand%0d_count", f), act_out.size(), 4);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
